// File: rtl/aes_pkg.sv
// ---------------------------------------------------------------------------
// aes_pkg
// Definitions shared by the AES cores and the serial master in front of
// each core.
//   AES_BLOCK_BITS  : width of one AES data block
//   state_t / ST_*  : 3-bit state encoding of the serial master FSM
//   key_bits_legal  : true when a key width is a legal AES key length
// ---------------------------------------------------------------------------
package aes_pkg;

  localparam int AES_BLOCK_BITS = 128;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE       = 3'd0;
  localparam state_t ST_SHIFT_DATA = 3'd1;
  localparam state_t ST_SHIFT_KEY  = 3'd2;
  localparam state_t ST_WAIT       = 3'd3;
  localparam state_t ST_GAP        = 3'd4;
  localparam state_t ST_CAPTURE    = 3'd5;
  localparam state_t ST_DONE       = 3'd6;

  // Nk*32 with Nk in {4,6,8}
  function automatic bit key_bits_legal(input int kb);
    return (kb == 128) || (kb == 192) || (kb == 256);
  endfunction

endpackage

// File: rtl/aes_serial_master_if.sv
// ---------------------------------------------------------------------------
// aes_serial_master_if
// Host-side handshake plus core-side serial lines of one serial master.
//   in_valid/in_ready/in_data/in_key : request handshake (block + key)
//   out_valid/out_data/err/busy      : result presentation
//   cs/miso                          : serial lines driven towards the core
//   mosi/finished                    : serial lines driven by the core
// modport master : the serial master itself
// modport slave  : whatever surrounds it (host logic and core)
// ---------------------------------------------------------------------------
interface aes_serial_master_if
  import aes_pkg::*;
#(
  parameter int KEY_BITS = 128
);

  logic                      in_valid;
  logic                      in_ready;
  logic [AES_BLOCK_BITS-1:0] in_data;
  logic [KEY_BITS-1:0]       in_key;
  logic                      out_valid;
  logic [AES_BLOCK_BITS-1:0] out_data;
  logic                      err;
  logic                      busy;
  logic                      cs;
  logic                      miso;
  logic                      mosi;
  logic                      finished;

  modport master (
    input  in_valid, in_data, in_key, mosi, finished,
    output in_ready, out_valid, out_data, err, busy, cs, miso
  );

  modport slave (
    output in_valid, in_data, in_key, mosi, finished,
    input  in_ready, out_valid, out_data, err, busy, cs, miso
  );

endinterface

// File: rtl/aes_piso_sipo.sv
// ---------------------------------------------------------------------------
// aes_piso_sipo
// Generic right-shifting register usable as PISO or SIPO.
//   clk, rst    : clock, synchronous active-high reset (clears to zero)
//   load        : parallel load of load_data (wins over shift_en)
//   shift_en    : shift one place towards bit 0, serial_in enters at the MSB
//   serial_out  : current bit 0
//   par_out     : whole register
// Used as SIPO, WIDTH shifts leave the first received bit in bit 0.
// ---------------------------------------------------------------------------
module aes_piso_sipo #(
  parameter int WIDTH = 128
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             shift_en,
  input  logic             serial_in,
  output logic             serial_out,
  output logic [WIDTH-1:0] par_out
);

  logic [WIDTH-1:0] sr_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      sr_reg <= '0;
    end else if (load) begin
      sr_reg <= load_data;
    end else if (shift_en) begin
      sr_reg <= {serial_in, sr_reg[WIDTH-1:1]};
    end
  end

  assign serial_out = sr_reg[0];
  assign par_out    = sr_reg;

endmodule

// File: rtl/aes_serial_master.sv
// ---------------------------------------------------------------------------
// aes_serial_master
// Host-side master for the bit-serial cs/miso/mosi/finished port of an AES
// core. Accepts block+key over valid/ready, shifts both out LSB-first with cs
// high, drops cs until the core reports finished, then raises cs again and
// collects the 128-bit result, presented with a one-cycle out_valid pulse.
//   clk, rst : clock, synchronous active-high reset
//   bus      : aes_serial_master_if.master (handshake, result, serial lines)
// Parameters: KEY_BITS (128/192/256), READ_LATENCY (>=1) cycles of cs high
// before the first valid mosi bit, TIMEOUT_CYCLES (>=2) WAIT cycles before
// the transfer is aborted with err=1.
// ---------------------------------------------------------------------------
module aes_serial_master
  import aes_pkg::*;
#(
  parameter int KEY_BITS       = 128,
  parameter int READ_LATENCY   = 1,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                clk,
  input  logic                rst,
  aes_serial_master_if.master bus
);

  localparam int     TW        = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [7:0]    DATA_LAST = 8'(AES_BLOCK_BITS - 1);
  localparam logic [7:0]    KEY_LAST  = 8'(KEY_BITS - 1);
  localparam logic [7:0]    GAP_LAST  = 8'(READ_LATENCY - 1);
  localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CYCLES - 1);

  generate
    if (!key_bits_legal(KEY_BITS)) begin : g_bad_key_bits
      $error("aes_serial_master: KEY_BITS must be 128, 192 or 256");
    end
    if (READ_LATENCY < 1 || READ_LATENCY > 256) begin : g_bad_read_latency
      $error("aes_serial_master: READ_LATENCY must be 1..256");
    end
    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
      $error("aes_serial_master: TIMEOUT_CYCLES must be >= 2");
    end
  endgenerate

  state_t                    state_reg, state_next;
  logic [7:0]                cnt_reg, cnt_next;
  logic [TW-1:0]             tmo_reg, tmo_next;
  logic                      timeout_hit;
  logic                      err_reg;
  logic [AES_BLOCK_BITS-1:0] out_data_reg;

  logic                      accept;
  logic                      data_shift, key_shift, res_shift;
  logic                      data_bit, key_bit;
  logic [AES_BLOCK_BITS-1:0] res_par;
  logic [AES_BLOCK_BITS-1:0] data_par_unused;
  logic [KEY_BITS-1:0]       key_par_unused;
  logic                      res_serial_unused;

  // ---- shift registers ------------------------------------------------------
  aes_piso_sipo #(.WIDTH(AES_BLOCK_BITS)) u_data_sr (
    .clk(clk), .rst(rst), .load(accept), .load_data(bus.in_data),
    .shift_en(data_shift), .serial_in(1'b0),
    .serial_out(data_bit), .par_out(data_par_unused)
  );

  aes_piso_sipo #(.WIDTH(KEY_BITS)) u_key_sr (
    .clk(clk), .rst(rst), .load(accept), .load_data(bus.in_key),
    .shift_en(key_shift), .serial_in(1'b0),
    .serial_out(key_bit), .par_out(key_par_unused)
  );

  // Cleared on accept so an aborted transfer reports an all-zero result.
  aes_piso_sipo #(.WIDTH(AES_BLOCK_BITS)) u_res_sr (
    .clk(clk), .rst(rst), .load(accept), .load_data('0),
    .shift_en(res_shift), .serial_in(bus.mosi),
    .serial_out(res_serial_unused), .par_out(res_par)
  );

  // ---- FSM: state register ----------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= '0;
      tmo_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      tmo_reg   <= tmo_next;
    end
  end

  // ---- FSM: next state ----------------------------------------------------------
  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    tmo_next    = tmo_reg;
    timeout_hit = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (bus.in_valid) begin
          state_next = ST_SHIFT_DATA;
          cnt_next   = '0;
        end
      end
      ST_SHIFT_DATA: begin
        if (cnt_reg == DATA_LAST) begin
          state_next = ST_SHIFT_KEY;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + 8'd1;
        end
      end
      ST_SHIFT_KEY: begin
        if (cnt_reg == KEY_LAST) begin
          state_next = ST_WAIT;
          tmo_next   = '0;
        end else begin
          cnt_next = cnt_reg + 8'd1;
        end
      end
      ST_WAIT: begin
        tmo_next = tmo_reg + TW'(1);
        // finished is ignored on the first WAIT cycle (tmo_reg==0): a flag
        // still high from the previous operation must not end this one.
        if (bus.finished && (tmo_reg != '0)) begin
          state_next = ST_GAP;
          cnt_next   = '0;
        end else if (tmo_reg == TMO_LAST) begin
          state_next  = ST_DONE;
          timeout_hit = 1'b1;
        end
      end
      ST_GAP: begin
        if (cnt_reg == GAP_LAST) begin
          state_next = ST_CAPTURE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + 8'd1;
        end
      end
      ST_CAPTURE: begin
        if (cnt_reg == DATA_LAST) begin
          state_next = ST_DONE;
        end else begin
          cnt_next = cnt_reg + 8'd1;
        end
      end
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // ---- FSM: outputs ---------------------------------------------------------------
  always_comb begin
    accept        = 1'b0;
    data_shift    = 1'b0;
    key_shift     = 1'b0;
    res_shift     = 1'b0;
    bus.cs        = 1'b0;
    bus.miso      = 1'b0;
    bus.out_valid = 1'b0;
    bus.in_ready  = 1'b0;
    bus.busy      = 1'b1;
    bus.err       = err_reg;
    // The last result bit lands in res_par on the edge entering DONE, so the
    // DONE cycle presents it directly; out_data_reg holds it afterwards.
    bus.out_data  = out_data_reg;
    case (state_reg)
      ST_IDLE: begin
        bus.in_ready = 1'b1;
        bus.busy     = 1'b0;
        accept       = bus.in_valid;
      end
      ST_SHIFT_DATA: begin
        bus.cs     = 1'b1;
        bus.miso   = data_bit;
        data_shift = 1'b1;
      end
      ST_SHIFT_KEY: begin
        bus.cs    = 1'b1;
        bus.miso  = key_bit;
        key_shift = 1'b1;
      end
      ST_GAP: bus.cs = 1'b1;
      ST_CAPTURE: begin
        bus.cs    = 1'b1;
        res_shift = 1'b1;
      end
      ST_DONE: begin
        bus.out_valid = 1'b1;
        bus.out_data  = res_par;
      end
      default: ;
    endcase
  end

  // ---- result / error holding registers -----------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      err_reg      <= 1'b0;
      out_data_reg <= '0;
    end else begin
      if ((state_next == ST_DONE) && (state_reg != ST_DONE)) begin
        err_reg <= timeout_hit;
      end
      if (state_reg == ST_DONE) begin
        out_data_reg <= res_par;
      end
    end
  end

endmodule
